cl_thread_state_ctrl: RTL
=========================

// Module: cl_thread_state_ctrl
// PURPOSE
//  Parametrised, registered multi-thread run-state controller for the core.
//  Holds one IDLE/RUN/ERR state per hardware thread and applies network wake/clear
//  commands, decoded kWAIT and exceptions to each thread.
//  Picks the next issuing thread round-robin among RUN threads, feeding fetch/PC select.
// PARAMETERS
//  NUM_THREADS  4   hardware thread contexts, 1..16
//  TID_W        $clog2(NUM_THREADS) (min 1)   thread-id width, derived, not overridden
//  ERR_CLR_EN   1   1: net clear moves ERR->IDLE; 0: ERR is sticky until reset
// PORTS
//  clk                 in   1            core clock
//  reset               in   1            async, active-high; all state to reset values
//  instruction_i       in   instruction_s  instruction in decode for thread instr_tid_i
//  instr_v_i           in   1            instruction_i is valid
//  instr_tid_i         in   TID_W        owning thread of instruction_i
//  exception_i         in   1            exception raised by instr_tid_i's instruction
//  stall_i             in   1            pipeline stall; blocks WAIT/exception/RR advance
//  net_wake_v_i        in   1            network PC-write wake command
//  net_wake_tid_i      in   TID_W        target thread of wake
//  net_clr_v_i         in   1            network error-clear command
//  net_clr_tid_i       in   TID_W        target thread of clear
//  state_o             out  NUM_THREADS x state_e  registered per-thread state
//  run_mask_o          out  NUM_THREADS  bit t = (state_o[t]==RUN)
//  sel_v_o             out  1            some thread is RUN
//  sel_tid_o           out  TID_W        round-robin selected RUN thread
//  all_idle_o          out  1            every thread IDLE
//  err_any_o           out  1            any thread in ERR
// BEHAVIOUR
//  Reset: every state_o=IDLE, RR pointer=0, sel_v_o=0, sel_tid_o=0, all_idle_o=1, err_any_o=0.
//  One clock; each state register updates on posedge clk; changes are visible the next cycle.
//  "act" = instr_v_i & ~stall_i & (instr_tid_i==t). Per thread t, next state, highest priority first:
//   1 RUN & act & exception_i            -> ERR (the exception overrides the WAIT/wake result)
//   2 RUN & act & kWAIT & wake to t      -> RUN (wake wins; no lost wakeup)
//   3 RUN & act & kWAIT                  -> IDLE
//   4 IDLE & wake to t                   -> RUN
//   5 ERR & clear to t & ERR_CLR_EN      -> IDLE
//   6 illegal/unknown encoding           -> ERR
//   otherwise hold
//  A wake to a RUN/ERR thread is dropped.
//  A clear to a non-ERR thread is dropped.
//  A command with tid >= NUM_THREADS is ignored.
//  stall_i=1 masks kWAIT and exception_i for that cycle (instruction finishes first).
//  Wake and clear take effect regardless of stall_i.
//  Wake and clear to different threads in the same cycle are both applied.
//  RR select (combinational from registered state and pointer):
//   first RUN thread at index >= ptr, wrapping modulo NUM_THREADS.
//   sel_v_o=0 gives sel_tid_o=0.
//  Pointer update: if sel_v_o & ~stall_i, ptr <= (sel_tid_o+1) mod NUM_THREADS; else hold.
//   Wrap from NUM_THREADS-1 to 0.
//  A thread leaving RUN is dropped from selection on the next cycle; no extra flush is needed.
//  NUM_THREADS=1: behaves as a single-thread IDLE/RUN/ERR machine; sel_tid_o=0 always.
//  Reset asserted mid-operation: immediate async return to reset values; pending commands are lost.
// STRUCTURE
//  state_e and instruction_s/kWAIT come from definitions.sv.
//  Add to the shared package: thread-id typedef, MAX_THREADS=16.
//  Sub-module cl_rr_thread_arb:
//   - NUM_THREADS-wide round-robin arbiter: req mask + pointer -> grant idx/valid.
//   - Owns the pointer register.
//  The top level holds the state-register array and the per-thread next-state logic (generate loop).
// TESTING
//  T1 reset, no cmds 10 cycles -> all IDLE, all_idle_o=1, sel_v_o=0.
//  T2 wake tid2 -> state_o[2]=RUN next cycle, sel_tid_o=2, run_mask_o=4'b0100.
//  T3 wake tids 0,1,3; no stall 6 cycles -> sel_tid_o sequence 0,1,3,0,1,3.
//      Repeat with stall_i high on cycle 3 -> pointer holds, tid 0 re-selected.
//  T4 tid1 RUN, kWAIT tid1 with wake tid1 same cycle -> stays RUN.
//      Repeat without the wake -> IDLE; repeat with stall_i=1 -> stays RUN.
//  T5 exception tid3 with ~stall -> ERR, err_any_o=1.
//      Wake tid3 -> ignored; clear tid3 -> IDLE (ERR_CLR_EN=1), stays ERR (ERR_CLR_EN=0).
//  T6 NUM_THREADS=3: wake tid 3 ignored; all RUN, ptr wraps 2->0.
//      Assert reset mid-run -> all IDLE within the same cycle.

Source files
------------

// File: rtl/cl_thread_state_ctrl_pkg.sv
`default_nettype none
// ==========================================================================
// cl_thread_state_ctrl_pkg: shared thread-state, instruction and tid types.
// Revision 1.0
// ==========================================================================
package cl_thread_state_ctrl_pkg;

  localparam int MAX_THREADS = 16;

  typedef logic [$clog2(MAX_THREADS)-1:0] tid_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] operand;
  } instruction_s;

  localparam logic [7:0] kWAIT = 8'h5A;

  function automatic logic is_kwait(input instruction_s instr);
    return instr.opcode == kWAIT;
  endfunction

  // A single-thread build still carries a 1-bit id so ports never go zero-width.
  function automatic int tid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cl_thread_state_ctrl_if.sv
`default_nettype none
// ==========================================================================
// cl_thread_state_ctrl_if: decode/network command inputs and thread status.
// Revision 1.0
// ==========================================================================
interface cl_thread_state_ctrl_if
  import cl_thread_state_ctrl_pkg::*;
#(
  parameter int NUM_THREADS = 4
);
  localparam int TID_W = tid_width(NUM_THREADS);

  instruction_s               instruction_i;
  logic                       instr_v_i;
  logic [TID_W-1:0]           instr_tid_i;
  logic                       exception_i;
  logic                       stall_i;
  logic                       net_wake_v_i;
  logic [TID_W-1:0]           net_wake_tid_i;
  logic                       net_clr_v_i;
  logic [TID_W-1:0]           net_clr_tid_i;
  state_e [NUM_THREADS-1:0]   state_o;
  logic [NUM_THREADS-1:0]     run_mask_o;
  logic                       sel_v_o;
  logic [TID_W-1:0]           sel_tid_o;
  logic                       all_idle_o;
  logic                       err_any_o;

  modport master (
    output instruction_i, instr_v_i, instr_tid_i, exception_i, stall_i,
           net_wake_v_i, net_wake_tid_i, net_clr_v_i, net_clr_tid_i,
    input  state_o, run_mask_o, sel_v_o, sel_tid_o, all_idle_o, err_any_o
  );

  modport slave (
    input  instruction_i, instr_v_i, instr_tid_i, exception_i, stall_i,
           net_wake_v_i, net_wake_tid_i, net_clr_v_i, net_clr_tid_i,
    output state_o, run_mask_o, sel_v_o, sel_tid_o, all_idle_o, err_any_o
  );

endinterface
`default_nettype wire

// File: rtl/cl_thread_state_ctrl_arb.sv
`default_nettype none
// ==========================================================================
// cl_rr_thread_arb: round-robin pick of the first requester at or after ptr.
// Revision 1.0
// ==========================================================================
module cl_rr_thread_arb
  import cl_thread_state_ctrl_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int TID_W       = tid_width(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_THREADS-1:0] req_i,
  input  logic                   adv_i,
  output logic                   grant_v_o,
  output logic [TID_W-1:0]       grant_idx_o
);

  logic [TID_W-1:0] ptr_q;
  logic [TID_W-1:0] ptr_d;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    int idx;
    idx         = 0;
    grant_v_o   = 1'b0;
    grant_idx_o = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_THREADS) begin
        idx = idx - NUM_THREADS;
      end
      if (req_i[idx]) begin
        grant_v_o   = 1'b1;
        grant_idx_o = TID_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_v_o && adv_i) begin
      ptr_d = (grant_idx_o == TID_W'(NUM_THREADS - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cl_thread_state_ctrl.sv
`default_nettype none
// ==========================================================================
// cl_thread_state_ctrl: per-thread IDLE/RUN/ERR state and round-robin issue.
// Revision 1.0
// ==========================================================================
module cl_thread_state_ctrl
  import cl_thread_state_ctrl_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter bit ERR_CLR_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  cl_thread_state_ctrl_if.slave bus
);

  localparam int TID_W = tid_width(NUM_THREADS);

  state_e [NUM_THREADS-1:0] state_q;
  state_e [NUM_THREADS-1:0] state_d;
  logic   [NUM_THREADS-1:0] run_mask;
  logic                     kwait;
  logic                     unused_operand;

  assign kwait          = is_kwait(bus.instruction_i);
  assign unused_operand = ^bus.instruction_i.operand;

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
    logic   act;
    logic   wake;
    logic   clr;
    state_e nxt;

    // Out-of-range tids never match any thread index, so they drop naturally.
    assign act  = bus.instr_v_i & ~bus.stall_i & (bus.instr_tid_i == TID_W'(t));
    assign wake = bus.net_wake_v_i & (bus.net_wake_tid_i == TID_W'(t));
    assign clr  = bus.net_clr_v_i & (bus.net_clr_tid_i == TID_W'(t));

    always_comb begin
      nxt = state_q[t];
      case (state_q[t])
        RUN: begin
          if (act && bus.exception_i) begin
            nxt = ERR;
          end else if (act && kwait) begin
            nxt = wake ? RUN : IDLE;
          end
        end
        IDLE: begin
          if (wake) begin
            nxt = RUN;
          end
        end
        ERR: begin
          if (clr && ERR_CLR_EN) begin
            nxt = IDLE;
          end
        end
        default: nxt = ERR;
      endcase
    end

    assign state_d[t]  = nxt;
    assign run_mask[t] = (state_q[t] == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        state_q[t] <= IDLE;
      end
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    bus.all_idle_o = 1'b1;
    bus.err_any_o  = 1'b0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (state_q[t] != IDLE) begin
        bus.all_idle_o = 1'b0;
      end
      if (state_q[t] == ERR) begin
        bus.err_any_o = 1'b1;
      end
    end
  end

  assign bus.state_o    = state_q;
  assign bus.run_mask_o = run_mask;

  cl_rr_thread_arb #(
    .NUM_THREADS (NUM_THREADS),
    .TID_W       (TID_W)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_i       (run_mask),
    .adv_i       (~bus.stall_i),
    .grant_v_o   (bus.sel_v_o),
    .grant_idx_o (bus.sel_tid_o)
  );

endmodule
`default_nettype wire
